// File: rtl/exec_unit_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM states, MUL iteration count.
package exec_unit_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 3;

  // One shift-add iteration per operand bit.
  localparam int unsigned MUL_ITERS  = DEF_DATA_W;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRA = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/exec_unit_mul_seq.sv
// Sequential shift-add multiplier: one partial product per clock, fixed ITERS-cycle latency.
// done/p describe the edge that performs the final iteration, so the parent can
// register the product on that same edge.
module mul_seq
  import exec_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ITERS  = MUL_ITERS
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] p
);

  localparam int unsigned CW = $clog2(ITERS);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              active_q, active_d;

  logic [DATA_W-1:0] addend;
  logic [DATA_W-1:0] acc_next;
  logic              last_iter;

  // Next iteration: conditionally add the shifted multiplicand, advance shifts and counter.
  always_comb begin
    addend    = b_q[0] ? a_q : '0;
    acc_next  = acc_q + addend;
    last_iter = active_q && (cnt_q == CNT_LAST);

    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    active_d = active_q;

    if (start) begin
      a_d      = a;
      b_d      = b;
      acc_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d = acc_next;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + CW'(1);
      if (last_iter) begin
        active_d = 1'b0;
      end
    end
  end

  // Multiplier state registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  // Product includes the iteration being performed on the completing edge.
  assign done = last_iter;
  assign p    = acc_next;

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus a sequential MUL, writing back through wa/wd/we.
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] dst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic              we,
  output logic              busy
);

  localparam int unsigned SHW = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              we_q, we_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_p;
  logic [DATA_W-1:0] alu_res;
  logic [SHW-1:0]    shamt;

  assign accept    = in_valid && in_ready_q;
  assign mul_start = accept && (op_e'(op) == OP_MUL);

  mul_seq #(
    .DATA_W (DATA_W),
    .ITERS  (DATA_W)
  ) u_mul (
    .clk   (clk),
    .n_rst (n_rst),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .p     (mul_p)
  );

  // Single-cycle ALU result; shifts use only the low log2(DATA_W) bits of b.
  always_comb begin
    shamt = b[SHW-1:0];
    case (op_e'(op))
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // FSM next state and writeback: we is a one-cycle pulse, wa/wd hold otherwise.
  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mul_start) begin
          dst_d   = dst;
          state_d = ST_MUL;
        end else if (accept) begin
          we_d = 1'b1;
          wa_d = dst;
          wd_d = alu_res;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          we_d    = 1'b1;
          wa_d    = dst_q;
          wd_d    = mul_p;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d == ST_MUL);
  end

  // Control and writeback registers; handshake outputs are registered copies of the next state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      dst_q      <= '0;
      wa_q       <= '0;
      wd_q       <= '0;
      we_q       <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dst_q      <= dst_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      we_q       <= we_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign wa       = wa_q;
  assign wd       = wd_q;
  assign we       = we_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;

endmodule
